// File: rtl/bram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bram_arbiter_pkg
// Shared types and constants for the imem/dmem block-RAM arbiter.
//   arb_state_t          : arbiter FSM states (IDLE, BUSY, RESP)
//   bram_req_t           : request latched onto the BRAM interface
//   DEFAULT_STARVE_LIMIT : default dmem grants allowed while imem is waiting
// ---------------------------------------------------------------------------
package bram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bram_req_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/bram_arb_select.sv
// ---------------------------------------------------------------------------
// bram_arb_select
// Combinational winner selection between the fetch and load/store ports.
// Configuration macro: BRAM_ARB_RR_EN
//   defined   : round-robin, rr_imem_next says which side wins a tie
//   undefined : dmem has priority, imem forced through once starve_cnt
//               reaches STARVE_LIMIT
// Ports:
//   imem_valid, dmem_valid : pending requests
//   starve_cnt             : consecutive dmem grants while imem waited
//   rr_imem_next           : 1 when imem is preferred on the next tie
//   grant_imem             : 1 = imem wins, 0 = dmem wins (meaningful only
//                            when at least one valid is high)
// ---------------------------------------------------------------------------
module bram_arb_select
    import bram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic       imem_valid,
    input  logic       dmem_valid,
    input  logic [3:0] starve_cnt,
    input  logic       rr_imem_next,
    output logic       grant_imem
);

`ifdef BRAM_ARB_RR_EN
    // The starve count and limit play no part in round-robin mode.
    logic unused_sel;
    assign unused_sel = |{starve_cnt, 4'(STARVE_LIMIT)};

    assign grant_imem = imem_valid && (!dmem_valid || rr_imem_next);
`else
    // The round-robin pointer plays no part in fixed-priority mode.
    logic unused_sel;
    assign unused_sel = rr_imem_next;

    assign grant_imem = imem_valid &&
                        (!dmem_valid || (starve_cnt == 4'(STARVE_LIMIT)));
`endif

endmodule

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
// Shares one single-ported BRAM between the instruction-fetch port (imem)
// and the load/store port (dmem). The winning request is latched onto the
// bram_* outputs until bram_ready, then the read data is returned to the
// owner together with a one-cycle ready pulse. All outputs are registered.
// Configuration macro: BRAM_ARB_RR_EN (round-robin instead of dmem priority
// with STARVE_LIMIT anti-starvation).
// Ports:
//   clock, reset                      : clock, async active-low reset
//   imem_valid/addr/rdata/ready       : fetch port
//   dmem_valid/addr/wdata/wstrb/rdata/ready : load/store port
//   bram_valid/instr/addr/wdata/wstrb : latched request towards the BRAM
//   bram_rdata, bram_ready            : BRAM response
// ---------------------------------------------------------------------------
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    arb_state_t state;
    bram_req_t  req;
    logic [3:0] starve_cnt;
    logic       rr_imem_next;
    logic       grant_imem;

    bram_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .imem_valid   (imem_valid),
        .dmem_valid   (dmem_valid),
        .starve_cnt   (starve_cnt),
        .rr_imem_next (rr_imem_next),
        .grant_imem   (grant_imem)
    );

    assign bram_instr = req.instr;
    assign bram_addr  = req.addr;
    assign bram_wdata = req.wdata;
    assign bram_wstrb = req.wstrb;

    // Grant in IDLE, hold the request in BUSY until the BRAM answers, then
    // spend one RESP cycle showing the ready pulse before accepting again.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            req          <= '0;
            bram_valid   <= 1'b0;
            imem_rdata   <= '0;
            imem_ready   <= 1'b0;
            dmem_rdata   <= '0;
            dmem_ready   <= 1'b0;
            starve_cnt   <= '0;
            rr_imem_next <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_valid || dmem_valid) begin
                        req.instr  <= grant_imem;
                        req.addr   <= grant_imem ? imem_addr : dmem_addr;
                        // imem is read-only: never forward store data for it
                        req.wdata  <= grant_imem ? 32'd0 : dmem_wdata;
                        req.wstrb  <= grant_imem ? 4'd0  : dmem_wstrb;
                        bram_valid <= 1'b1;
                        state      <= BUSY;
`ifdef BRAM_ARB_RR_EN
                        rr_imem_next <= !grant_imem;
`else
                        // Only dmem wins that made imem wait count as starvation
                        if (grant_imem) begin
                            starve_cnt <= '0;
                        end else if (imem_valid) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (bram_ready) begin
                        if (req.instr) begin
                            imem_rdata <= bram_rdata;
                            imem_ready <= 1'b1;
                        end else begin
                            dmem_rdata <= bram_rdata;
                            dmem_ready <= 1'b1;
                        end
                        req        <= '0;
                        bram_valid <= 1'b0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    imem_ready <= 1'b0;
                    dmem_ready <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
// Directed self-checking bench for bram_arbiter with a small BRAM model.
// Memory word i initially reads 32'hC0DE_0000 | i until written.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata = 32'd0;
    logic        bram_ready = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    int bram_cycle   = 0;

    always #5 clock = ~clock;

    bram_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .bram_valid (bram_valid),
        .bram_instr (bram_instr),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata),
        .bram_ready (bram_ready)
    );

    // BRAM model: answers bram_cycle edges after it first sees bram_valid,
    // returning the old word and applying byte-strobed writes.
    logic [31:0] mem [0:255];
    logic        mem_written [0:255] = '{default: 1'b0};
    int          model_cnt = 0;

    always @(posedge clock) begin
        logic [7:0]  idx;
        logic [31:0] word;
        idx  = bram_addr[9:2];
        word = mem_written[idx] ? mem[idx] : (32'hC0DE_0000 | {24'd0, idx});
        if (bram_ready) begin
            bram_ready <= 1'b0;
            model_cnt  <= 0;
        end else if (bram_valid) begin
            if (model_cnt >= bram_cycle) begin
                bram_ready <= 1'b1;
                bram_rdata <= word;
                for (int b = 0; b < 4; b++) begin
                    if (bram_wstrb[b]) word[8*b +: 8] = bram_wdata[8*b +: 8];
                end
                mem[idx]         = word;
                mem_written[idx] = 1'b1;
                model_cnt        <= 0;
            end else begin
                model_cnt <= model_cnt + 1;
            end
        end else begin
            model_cnt <= 0;
        end
    end

    // Issues one dmem transaction from a negedge and returns at a negedge
    // one cycle after the ready pulse; lat counts edges until ready is seen.
    task automatic do_dmem(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] rdata,
                           output int lat, output logic saw_instr);
        dmem_addr  = addr;
        dmem_wdata = wdata;
        dmem_wstrb = wstrb;
        dmem_valid = 1'b1;
        lat        = 0;
        saw_instr  = 1'b0;
        while (lat < 60) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
            if (bram_valid && bram_instr) saw_instr = 1'b1;
            if (dmem_ready) break;
        end
        rdata      = dmem_rdata;
        dmem_valid = 1'b0;
        dmem_wstrb = 4'd0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        imem_valid = 1'b0;
        imem_addr  = 32'd0;
        dmem_valid = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_wstrb = 4'd0;
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({bram_valid, bram_instr, bram_wstrb, imem_ready, dmem_ready} !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 00000000",
                     {bram_valid, bram_instr, bram_wstrb, imem_ready, dmem_ready});
        end
        tests_run++;
        if (bram_addr !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bram_addr: got %h expected 0", bram_addr);
        end
        tests_run++;
        if (bram_wdata !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bram_wdata: got %h expected 0", bram_wdata);
        end
        tests_run++;
        if ({imem_rdata, dmem_rdata} !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdata: got %h %h expected 0 0", imem_rdata, dmem_rdata);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_load();
        logic imem_seen;
        logic [31:0] exp_data;
        exp_data   = 32'hC0DE_0004;
        imem_seen  = 1'b0;
        dmem_addr  = 32'h10;
        dmem_wdata = 32'd0;
        dmem_wstrb = 4'd0;
        dmem_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        imem_seen |= imem_ready;
        tests_run++;
        if ({bram_valid, bram_instr, dmem_ready} !== 3'b100 || bram_addr !== 32'h10) begin
            tests_failed++;
            $display("[TB] FAIL load_grant: got valid/instr/ready %b addr %h expected 100 addr 10",
                     {bram_valid, bram_instr, dmem_ready}, bram_addr);
        end
        @(posedge clock);
        @(negedge clock);
        imem_seen |= imem_ready;
        tests_run++;
        if ({bram_valid, dmem_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL load_hold: got valid/ready %b expected 10", {bram_valid, dmem_ready});
        end
        @(posedge clock);
        @(negedge clock);
        imem_seen |= imem_ready;
        tests_run++;
        if ({bram_valid, dmem_ready} !== 2'b01 || dmem_rdata !== exp_data) begin
            tests_failed++;
            $display("[TB] FAIL load_ready: got valid/ready %b data %h expected 01 data %h",
                     {bram_valid, dmem_ready}, dmem_rdata, exp_data);
        end
        dmem_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        imem_seen |= imem_ready;
        tests_run++;
        if (dmem_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_pulse_width: got ready %b expected 0", dmem_ready);
        end
        tests_run++;
        if (imem_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_imem_quiet: got imem_ready seen %b expected 0", imem_seen);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rdata;
        int          lat;
        logic        saw_instr;
        logic        any_instr;
        do_dmem(32'h20, 32'hA5A5_1234, 4'b0101, rdata, lat, saw_instr);
        any_instr = saw_instr;
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("[TB] FAIL store_latency: got %0d expected 3", lat);
        end
        do_dmem(32'h20, 32'd0, 4'd0, rdata, lat, saw_instr);
        any_instr |= saw_instr;
        tests_run++;
        if (rdata !== 32'hC0A5_0034) begin
            tests_failed++;
            $display("[TB] FAIL store_readback: got %h expected c0a50034", rdata);
        end
        tests_run++;
        if (any_instr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL store_instr: got bram_instr seen %b expected 0", any_instr);
        end
    endtask

    task automatic test_imem_fetch();
        int   lat;
        logic dmem_seen;
        dmem_seen  = 1'b0;
        dmem_wdata = 32'hFFFF_FFFF;
        dmem_wstrb = 4'hF;
        dmem_valid = 1'b0;
        imem_addr  = 32'h30;
        imem_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({bram_valid, bram_instr, bram_wstrb} !== 6'b110000 || bram_wdata !== 32'd0
            || bram_addr !== 32'h30) begin
            tests_failed++;
            $display("[TB] FAIL fetch_busy: got v/i/strb %b wdata %h addr %h expected 110000 0 30",
                     {bram_valid, bram_instr, bram_wstrb}, bram_wdata, bram_addr);
        end
        lat = 1;
        while (lat < 60 && !imem_ready) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
            dmem_seen |= dmem_ready;
        end
        tests_run++;
        if (lat !== 3 || imem_rdata !== 32'hC0DE_000C) begin
            tests_failed++;
            $display("[TB] FAIL fetch_data: got lat %0d data %h expected 3 c0de000c", lat, imem_rdata);
        end
        tests_run++;
        if (dmem_rdata !== 32'hC0A5_0034 || dmem_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fetch_dmem_untouched: got %h ready %b expected c0a50034 0",
                     dmem_rdata, dmem_seen);
        end
        imem_valid = 1'b0;
        dmem_wdata = 32'd0;
        dmem_wstrb = 4'd0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_contention();
        logic [9:0] got;
        logic [9:0] expected;
        int         n_grants;
        logic       both_ready;
`ifdef BRAM_ARB_RR_EN
        expected = 10'b0101010101;
`else
        expected = 10'b1000010000;
`endif
        got        = '0;
        n_grants   = 0;
        both_ready = 1'b0;
        pulse_reset();
        imem_addr  = 32'h40;
        dmem_addr  = 32'h44;
        dmem_wstrb = 4'd0;
        imem_valid = 1'b1;
        dmem_valid = 1'b1;
        for (int c = 0; c < 200 && n_grants < 10; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (imem_ready && dmem_ready) both_ready = 1'b1;
            if (imem_ready) begin
                got[n_grants] = 1'b1;
                n_grants++;
            end else if (dmem_ready) begin
                n_grants++;
            end
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if (n_grants !== 10 || both_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL contention_progress: got %0d grants both %b expected 10 0",
                     n_grants, both_ready);
        end
        tests_run++;
        if (got !== expected) begin
            tests_failed++;
            $display("[TB] FAIL contention_order: got %b expected %b (bit k = kth grant to imem)",
                     got, expected);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic        ready_seen;
        logic [31:0] rdata;
        int          lat;
        logic        saw_instr;
        bram_cycle = 3;
        ready_seen = 1'b0;
        dmem_addr  = 32'h10;
        dmem_wstrb = 4'd0;
        dmem_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({bram_valid, imem_ready, dmem_ready} !== 3'b000 || bram_addr !== 32'd0
            || {imem_rdata, dmem_rdata} !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got v/ir/dr %b addr %h rdata %h %h expected 000 0 0 0",
                     {bram_valid, imem_ready, dmem_ready}, bram_addr, imem_rdata, dmem_rdata);
        end
        dmem_valid = 1'b0;
        repeat (6) begin
            @(negedge clock);
            ready_seen |= (imem_ready | dmem_ready | bram_valid);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            ready_seen |= (imem_ready | dmem_ready | bram_valid);
        end
        tests_run++;
        if (ready_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_no_pulse: got activity %b expected 0", ready_seen);
        end
        do_dmem(32'h10, 32'd0, 4'd0, rdata, lat, saw_instr);
        tests_run++;
        if (lat !== 6 || rdata !== 32'hC0DE_0004) begin
            tests_failed++;
            $display("[TB] FAIL midreset_recover: got lat %0d data %h expected 6 c0de0004", lat, rdata);
        end
        bram_cycle = 0;
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_load();
        test_imem_fetch();
        test_contention();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
